// File: rtl/mos6502_int_ctrl_pkg.sv
// mos6502_int_ctrl_pkg: FSM/source encodings and default vectors for the interrupt front-end
package mos6502_int_ctrl_pkg;
  typedef enum logic [1:0] {ST_RES, ST_IDLE, ST_TAKEN, ST_LOCKED} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_NMI, SRC_IRQ, SRC_BRK} src_e;
  localparam logic [15:0] DEF_NMI_VEC = 16'hFFFA;
  localparam logic [15:0] DEF_RES_VEC = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VEC = 16'hFFFE;
endpackage

// File: rtl/mos6502_int_ctrl_sync_edge.sv
// mos6502_int_ctrl_sync_edge: clk_en-gated synchroniser, optionally followed by falling-edge detect
module mos6502_int_ctrl_sync_edge #(
  parameter int W = 1,
  parameter int STAGES = 2,
  parameter bit EDGE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] sync_q [STAGES];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < STAGES; i++) sync_q[i] <= '1;
    else if (en) begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  // edge pulse is held while en is low, so it lasts exactly one qualified cycle
  if (EDGE) begin : g_edge
    logic [W-1:0] prev_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) prev_q <= '1;
      else if (en) prev_q <= sync_q[STAGES-1];
    assign q_o = prev_q & ~sync_q[STAGES-1];
  end else begin : g_lvl
    assign q_o = sync_q[STAGES-1];
  end
endmodule

// File: rtl/mos6502_int_ctrl.sv
// mos6502_int_ctrl: prioritised RESET/NMI/IRQ front-end with vectoring and NMI hijack
module mos6502_int_ctrl
  import mos6502_int_ctrl_pkg::*;
#(
  parameter int          N_IRQ       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter bit          VECTORED    = 1'b0,
  parameter logic [15:0] NMI_VEC     = DEF_NMI_VEC,
  parameter logic [15:0] RES_VEC     = DEF_RES_VEC,
  parameter logic [15:0] IRQ_VEC     = DEF_IRQ_VEC
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             clk_en,
  input  logic             nNMI,
  input  logic [N_IRQ-1:0] nIRQ,
  input  logic [N_IRQ-1:0] irq_en,
  input  logic             nSO,
  input  logic             I_mask,
  input  logic             NEXT_T,
  input  logic             BRK,
  input  logic             VEC_LOCK,
  input  logic             ACK,
  output logic             nRESET_req,
  output logic             nNMI_req,
  output logic             nIRQ_req,
  output logic             SO_req,
  output logic [3:0]       irq_id,
  output logic [15:0]      VEC_ADDR,
  output logic [N_IRQ-1:0] pending
);
  function automatic logic [3:0] prio(input logic [N_IRQ-1:0] p);
    prio = 4'd0;
    for (int k = N_IRQ - 1; k >= 0; k--) if (p[k]) prio = 4'(k);
  endfunction
  logic nmi_fall, so_fall, nmi_latch_q, nmi_latch_d, so_q, irq_hit;
  logic [N_IRQ-1:0] irq_s;
  logic [3:0] id_q, id_d;
  state_e state_q, state_d;
  src_e src_q, src_d;
  mos6502_int_ctrl_sync_edge #(.W(2), .STAGES(SYNC_STAGES), .EDGE(1'b1)) u_edge (
    .clk(clk), .rst(RESET), .en(clk_en), .d_i({nSO, nNMI}), .q_o({so_fall, nmi_fall})
  );
  mos6502_int_ctrl_sync_edge #(.W(N_IRQ), .STAGES(SYNC_STAGES), .EDGE(1'b0)) u_irq (
    .clk(clk), .rst(RESET), .en(clk_en), .d_i(nIRQ), .q_o(irq_s)
  );
  assign pending = ~irq_s & irq_en;
  assign irq_hit = |pending & ~I_mask;
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    id_d = id_q;
    // a fresh edge coinciding with the NMI ACK keeps the latch set
    nmi_latch_d = nmi_fall | (nmi_latch_q & ~(state_q == ST_LOCKED && src_q == SRC_NMI && ACK));
    case (state_q)
      ST_RES: state_d = ACK ? ST_IDLE : ST_RES;
      ST_IDLE:
        if (NEXT_T && (nmi_latch_q || irq_hit)) begin
          state_d = ST_TAKEN;
          src_d = nmi_latch_q ? SRC_NMI : SRC_IRQ;
          id_d = prio(pending);
        end else if (BRK) begin
          state_d = ST_TAKEN;
          src_d = SRC_BRK;
        end
      ST_TAKEN:
        if (VEC_LOCK) state_d = ST_LOCKED;
        else if (nmi_fall || nmi_latch_q) src_d = SRC_NMI;
      ST_LOCKED:
        if (ACK) begin
          state_d = ST_IDLE;
          src_d = SRC_NONE;
        end
      default: state_d = ST_RES;
    endcase
  end
  always_ff @(posedge clk or posedge RESET)
    if (RESET) begin
      state_q <= ST_RES;
      src_q <= SRC_NONE;
      id_q <= 4'd0;
      nmi_latch_q <= 1'b0;
      so_q <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      src_q <= src_d;
      id_q <= id_d;
      nmi_latch_q <= nmi_latch_d;
      so_q <= so_fall;
    end
  assign nRESET_req = state_q != ST_RES;
  assign nNMI_req = src_q != SRC_NMI;
  assign nIRQ_req = src_q != SRC_IRQ;
  assign SO_req = so_q;
  assign irq_id = src_q == SRC_IRQ ? id_q : 4'd0;
  assign VEC_ADDR = state_q == ST_RES ? RES_VEC :
                    src_q == SRC_NMI ? NMI_VEC :
                    (src_q == SRC_IRQ && VECTORED) ? IRQ_VEC - {11'd0, id_q, 1'b0} - 16'd2 : IRQ_VEC;
endmodule
